sha_256_ctrl: RTL and testbench

- Stream-to-block sequencer for the sha_256 core.
- Accepts a message as 32-bit big-endian words with a valid/ready handshake and buffers them into 512-bit blocks.
- Applies FIPS 180-4 padding and the 64-bit bit-length, issues each block to the core with correct Index/Enable, and returns the final digest on a held valid/ready output.
- Sits between the bus-side message source and one sha_256 instance.

---
 rtl/sha_256_ctrl_if.sv | 23 ++
 rtl/sha_256_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_sha_256_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_256_ctrl_if.sv
// Message-stream and digest handshake bundle for the sha_256 block sequencer.
// The master side produces message words and consumes the digest; the slave
// side is the controller.
interface sha_256_ctrl_if;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic         s_ready;
    logic [255:0] hash;
    logic         hash_valid;
    logic         hash_ready;

    modport master (
        output s_data, s_valid, s_last, s_bytes, hash_ready,
        input  s_ready, hash, hash_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, s_bytes, hash_ready,
        output s_ready, hash, hash_valid
    );
endinterface

// File: rtl/sha_256_ctrl.sv
// Stream-to-block sequencer for one sha_256 core: packs big-endian words into
// 512-bit blocks, appends the 0x80 marker and 64-bit bit length, launches each
// block with a one-cycle enable and returns the digest on a held valid/ready.
// Optional feature: define SHA_CTRL_SHA224_EN to add the per-message 'mode'
// input (0 = SHA-224, 1 = SHA-256); otherwise core_operation = DEFAULT_OP.
module sha_256_ctrl #(
    parameter int unsigned DEFAULT_OP = 1,
    parameter int unsigned LEN_W      = 64
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SHA_CTRL_SHA224_EN
    input  logic          mode,
`endif
    sha_256_ctrl_if.slave s,
    output logic [511:0]  core_data,
    output logic [63:0]   core_index,
    output logic [1:0]    core_operation,
    output logic          core_enable,
    input  logic [255:0]  core_hash,
    input  logic          core_ready,
    output logic          busy
);

    typedef enum logic [2:0] {StIdle, StFill, StPad, StStart, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        buf_q [16];
    logic [31:0]        buf_d [16];
    logic [3:0]         ptr_q, ptr_d;
    // Next word position to pad; 16 means the block is already full.
    logic [4:0]         pad_pos_q, pad_pos_d;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic [63:0]        blk_cnt_q, blk_cnt_d;
    logic               final_q, final_d;
    logic               len_pend_q, len_pend_d;
    // Marker word did not fit: the length block must start with 0x80000000.
    logic               mark_pend_q, mark_pend_d;
    logic [511:0]       core_data_q, core_data_d;
    logic [63:0]        core_index_q, core_index_d;
    logic               core_enable_q, core_enable_d;
    logic [255:0]       hash_q, hash_d;
    logic               hash_valid_q, hash_valid_d;
    logic               s_ready_q, s_ready_d;
    logic               busy_q, busy_d;
`ifdef SHA_CTRL_SHA224_EN
    logic               mode_q, mode_d;
`endif

    logic [2:0]         eff_bytes;
    logic [31:0]        keep_mask;
    logic [31:0]        mark_word;
    logic [LEN_W+2:0]   bits_ext;
    logic [63:0]        bit_len;
    logic [255:0]       digest;

    assign s.s_ready    = s_ready_q;
    assign s.hash       = hash_q;
    assign s.hash_valid = hash_valid_q;
    assign core_data    = core_data_q;
    assign core_index   = core_index_q;
    assign core_enable  = core_enable_q;
    assign busy         = busy_q;
`ifdef SHA_CTRL_SHA224_EN
    assign core_operation = {1'b0, mode_q};
    assign digest = mode_q ? core_hash : {core_hash[255:32], 32'h0};
`else
    assign core_operation = 2'(DEFAULT_OP);
    assign digest = core_hash;
`endif

    // Tail-word byte mask and in-word marker for the final word.
    always_comb begin
        eff_bytes = (s.s_bytes > 3'd4) ? 3'd4 : s.s_bytes;
        keep_mask = 32'hFFFF_FFFF;
        mark_word = 32'h0;
        case (eff_bytes)
            3'd0: begin keep_mask = 32'h0000_0000; mark_word = 32'h8000_0000; end
            3'd1: begin keep_mask = 32'hFF00_0000; mark_word = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hFFFF_0000; mark_word = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hFFFF_FF00; mark_word = 32'h0000_0080; end
            default: begin keep_mask = 32'hFFFF_FFFF; mark_word = 32'h0; end
        endcase
        bits_ext = {bytes_q, 3'b000};
        bit_len  = 64'(bits_ext);
    end

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        ptr_d         = ptr_q;
        pad_pos_d     = pad_pos_q;
        bytes_d       = bytes_q;
        blk_cnt_d     = blk_cnt_q;
        final_d       = final_q;
        len_pend_d    = len_pend_q;
        mark_pend_d   = mark_pend_q;
        core_data_d   = core_data_q;
        core_index_d  = core_index_q;
        core_enable_d = 1'b0;
        hash_d        = hash_q;
        hash_valid_d  = hash_valid_q;
`ifdef SHA_CTRL_SHA224_EN
        mode_d        = mode_q;
`endif

        unique case (state_q)
            StIdle: state_d = StFill;

            StFill: begin
                if (s.s_valid && s_ready_q) begin
`ifdef SHA_CTRL_SHA224_EN
                    if (!busy_q) mode_d = mode;
`endif
                    if (!s.s_last) begin
                        buf_d[ptr_q] = s.s_data;
                        ptr_d        = ptr_q + 4'd1;
                        bytes_d      = bytes_q + LEN_W'(4);
                        if (ptr_q == 4'd15) state_d = StStart;
                    end else begin
                        bytes_d = bytes_q + LEN_W'(eff_bytes);
                        ptr_d   = 4'd0;
                        if (eff_bytes < 3'd4) begin
                            buf_d[ptr_q] = (s.s_data & keep_mask) | mark_word;
                            pad_pos_d    = {1'b0, ptr_q} + 5'd1;
                        end else begin
                            buf_d[ptr_q] = s.s_data;
                            if (ptr_q != 4'd15) begin
                                buf_d[ptr_q + 4'd1] = 32'h8000_0000;
                                pad_pos_d           = {1'b0, ptr_q} + 5'd2;
                            end else begin
                                mark_pend_d = 1'b1;
                                pad_pos_d   = 5'd16;
                            end
                        end
                        state_d = StPad;
                    end
                end
            end

            StPad: begin
                if (len_pend_q) begin
                    for (int i = 0; i < 16; i++) buf_d[i] = 32'h0;
                    if (mark_pend_q) buf_d[0] = 32'h8000_0000;
                    buf_d[14]   = bit_len[63:32];
                    buf_d[15]   = bit_len[31:0];
                    final_d     = 1'b1;
                    len_pend_d  = 1'b0;
                    mark_pend_d = 1'b0;
                end else begin
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) >= pad_pos_q) buf_d[i] = 32'h0;
                    end
                    if (pad_pos_q <= 5'd14) begin
                        buf_d[14] = bit_len[63:32];
                        buf_d[15] = bit_len[31:0];
                        final_d   = 1'b1;
                    end else begin
                        len_pend_d = 1'b1;
                    end
                end
                state_d = StStart;
            end

            StStart: begin
                for (int i = 0; i < 16; i++) core_data_d[i*32 +: 32] = buf_q[i];
                blk_cnt_d     = blk_cnt_q + 64'd1;
                core_index_d  = blk_cnt_q + 64'd1;
                core_enable_d = 1'b1;
                state_d       = StWait;
            end

            StWait: begin
                if (core_ready) begin
                    if (final_q) begin
                        hash_d       = digest;
                        hash_valid_d = 1'b1;
                        state_d      = StDone;
                    end else if (len_pend_q) begin
                        state_d = StPad;
                    end else begin
                        state_d = StFill;
                    end
                end
            end

            StDone: begin
                if (s.hash_ready) begin
                    hash_valid_d = 1'b0;
                    ptr_d        = 4'd0;
                    bytes_d      = '0;
                    blk_cnt_d    = 64'd0;
                    final_d      = 1'b0;
                    len_pend_d   = 1'b0;
                    mark_pend_d  = 1'b0;
                    state_d      = StFill;
                end
            end

            default: state_d = StIdle;
        endcase

        s_ready_d = (state_d == StFill);
        busy_d    = !((state_d == StFill && ptr_d == 4'd0 && bytes_d == '0) ||
                      state_d == StDone || state_d == StIdle);
    end

    // Single register bank for the FSM, buffer and outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
            ptr_q         <= 4'd0;
            pad_pos_q     <= 5'd0;
            bytes_q       <= '0;
            blk_cnt_q     <= 64'd0;
            final_q       <= 1'b0;
            len_pend_q    <= 1'b0;
            mark_pend_q   <= 1'b0;
            core_data_q   <= '0;
            core_index_q  <= 64'd0;
            core_enable_q <= 1'b0;
            hash_q        <= '0;
            hash_valid_q  <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SHA_CTRL_SHA224_EN
            mode_q        <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            ptr_q         <= ptr_d;
            pad_pos_q     <= pad_pos_d;
            bytes_q       <= bytes_d;
            blk_cnt_q     <= blk_cnt_d;
            final_q       <= final_d;
            len_pend_q    <= len_pend_d;
            mark_pend_q   <= mark_pend_d;
            core_data_q   <= core_data_d;
            core_index_q  <= core_index_d;
            core_enable_q <= core_enable_d;
            hash_q        <= hash_d;
            hash_valid_q  <= hash_valid_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
`ifdef SHA_CTRL_SHA224_EN
            mode_q        <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha_256_ctrl.sv
// Bench for sha_256_ctrl: a behavioural SHA-256 compression core answers each
// enable; expected block indices and digests are queued when a message is
// driven and popped when the controller produces them.
module tb_sha_256_ctrl;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_56 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_256_ctrl_if bus();
    logic [511:0] core_data;
    logic [63:0]  core_index;
    logic [1:0]   core_operation;
    logic         core_enable;
    logic [255:0] core_hash = '0;
    logic         core_ready = 1'b0;
    logic         busy;
`ifdef SHA_CTRL_SHA224_EN
    logic         mode = 1'b1;
`endif

    sha_256_ctrl dut (
        .clk            (clk),
        .rst            (rst),
`ifdef SHA_CTRL_SHA224_EN
        .mode           (mode),
`endif
        .s              (bus),
        .core_data      (core_data),
        .core_index     (core_index),
        .core_operation (core_operation),
        .core_enable    (core_enable),
        .core_hash      (core_hash),
        .core_ready     (core_ready),
        .busy           (busy)
    );

    int total = 0;
    int bad = 0;
    logic [255:0] dig_q [$];
    logic [63:0]  idx_q [$];
    logic [1:0]   exp_op = 2'd1;
    logic         prev_en = 1'b0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Reference SHA-256 over a byte string with standard padding.
    function automatic logic [255:0] sha_ref(input logic [7:0] m [$]);
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] h;
        h  = IV256;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        for (int c = 0; c < p.size(); c += 64) begin
            for (int i = 0; i < 16; i++)
                blk[i*32 +: 32] = {p[c+4*i], p[c+4*i+1], p[c+4*i+2], p[c+4*i+3]};
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    // Behavioural core: result appears eight cycles after enable.
    logic [255:0] res = '0;
    int           cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            cnt        <= 0;
            core_ready <= 1'b0;
            core_hash  <= '0;
            res        <= '0;
        end else begin
            core_ready <= 1'b0;
            if (core_enable) begin
                res <= sha_compress((core_index == 64'd1) ?
                                    ((core_operation == 2'd0) ? IV224 : IV256) : res, core_data);
                cnt <= 8;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    core_ready <= 1'b1;
                    core_hash  <= res;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Enable monitor: pulse width, block index and operation.
    always @(negedge clk) begin
        if (!rst && core_enable) begin
            chk("enable_width", 256'(prev_en), 256'(1'b0));
            chk("core_index", 256'(core_index),
                256'((idx_q.size() > 0) ? idx_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF));
            chk("core_operation", 256'(core_operation), 256'(exp_op));
        end
        prev_en = core_enable;
    end

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
        int n = 0;
        @(negedge clk);
        bus.s_data = d; bus.s_last = l; bus.s_bytes = b; bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("s_ready_timeout", 256'(bus.s_ready), 256'(1'b1));
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] w [$], input int lb, input bit use_ref,
                            input logic [255:0] exp_const);
        logic [7:0]  m [$];
        logic [31:0] wd;
        int nb, nblk, last;
        last = w.size() - 1;
        for (int j = 0; j <= last; j++) begin
            wd = w[j];
            nb = (j == last) ? lb : 4;
            for (int k = 0; k < nb; k++) m.push_back(wd[31-8*k -: 8]);
        end
        nblk = (m.size() + 9 + 63) / 64;
        for (int i = 1; i <= nblk; i++) idx_q.push_back(64'(i));
        dig_q.push_back(use_ref ? sha_ref(m) : exp_const);
        for (int j = 0; j <= last; j++) send(w[j], j == last, (j == last) ? 3'(lb) : 3'd4);
    endtask

    task automatic wait_digest(input string tag);
        int n = 0;
        while (!bus.hash_valid && n < 2000) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 256'(bus.hash_valid), 256'(1'b1));
        chk({tag, "_hash"}, bus.hash, (dig_q.size() > 0) ? dig_q.pop_front() : '1);
        chk({tag, "_blocks"}, 256'(idx_q.size()), 256'(0));
    endtask

    task automatic release_digest(input string tag);
        @(negedge clk); bus.hash_ready = 1'b1;
        @(posedge clk); #1; bus.hash_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 256'(bus.hash_valid), 256'(1'b0));
        chk({tag, "_s_ready"}, 256'(bus.s_ready), 256'(1'b1));
        chk({tag, "_idle"}, 256'(busy), 256'(1'b0));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, 256'(bus.s_ready), 256'(1'b0));
        chk({tag, "_enable"}, 256'(core_enable), 256'(1'b0));
        chk({tag, "_index"}, 256'(core_index), 256'(0));
        chk({tag, "_data_lo"}, core_data[255:0], '0);
        chk({tag, "_data_hi"}, core_data[511:256], '0);
        chk({tag, "_hash"}, bus.hash, '0);
        chk({tag, "_valid"}, 256'(bus.hash_valid), 256'(1'b0));
        chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
    endtask

    initial begin
        logic [31:0] w [$];
        int n;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_bytes = '0;
        bus.hash_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk("por_fill_ready", 256'(bus.s_ready), 256'(1'b1));
        chk("por_busy", 256'(busy), 256'(1'b0));

        // "abc"
        w = '{32'h61626300};
        send_msg(w, 3, 1'b0, D_ABC);
        wait_digest("abc");
        release_digest("abc");

        // Empty message
        w = '{32'h0};
        send_msg(w, 0, 1'b0, D_EMPTY);
        wait_digest("empty");
        release_digest("empty");

        // 56-byte message, then hold the digest under backpressure
        w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
              32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
              32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        send_msg(w, 4, 1'b0, D_56);
        chk("m56_busy", 256'(busy), 256'(1'b1));
        wait_digest("m56");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 256'(bus.hash_valid), 256'(1'b1));
            chk("bp_hash", bus.hash, D_56);
            chk("bp_s_ready", 256'(bus.s_ready), 256'(1'b0));
        end
        release_digest("m56");

        // 64 bytes: marker lands in the next block
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(32'h00010203 + 32'h04040404 * 32'(i));
        send_msg(w, 4, 1'b1, '0);
        wait_digest("m64");
        release_digest("m64");

        // 58 bytes: marker in word 14 pushes the length to a second block
        void'(w.pop_back());
        send_msg(w, 2, 1'b1, '0);
        wait_digest("m58");
        release_digest("m58");

        // Reset while block 1 of a two-block message is in flight
        idx_q.push_back(64'd1);
        for (int i = 0; i < 16; i++) send(32'hA5A50000 + 32'(i), 1'b0, 3'd4);
        n = 0;
        do begin @(negedge clk); n++; end while (!core_enable && n < 100);
        chk("mid_enable_seen", 256'(core_enable), 256'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid");
        rst = 1'b0;
        idx_q.delete();
        @(negedge clk);
        chk("mid_fill_ready", 256'(bus.s_ready), 256'(1'b1));
        w = '{32'h61626300};
        send_msg(w, 3, 1'b0, D_ABC);
        wait_digest("abc2");
        release_digest("abc2");

`ifdef SHA_CTRL_SHA224_EN
        mode = 1'b0;
        exp_op = 2'd0;
        send_msg(w, 3, 1'b0, {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7,
                              32'h0});
        mode = 1'b1;
        wait_digest("abc224");
        release_digest("abc224");
        exp_op = 2'd1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
